// File: rtl/traffic_arbiter_n_if.sv
// Sense/grant bundle between the intersection arbiter and the approach sensors/lights.
interface traffic_arbiter_n_if #(
   parameter int NUM_DIRS = 4
);
   logic [NUM_DIRS-1:0] sense;
   logic [NUM_DIRS-1:0] go;
   logic [NUM_DIRS-1:0] pending;
   logic [1:0]          phase;

   modport master (output sense, input go, pending, phase);
   modport slave  (input sense, output go, pending, phase);
endinterface

// File: rtl/traffic_arbiter_n.sv
// Two-group intersection arbiter: latches sense pulses, grants one compatible group at a time,
// caps green time while the other group waits, and inserts an all-red clearance between groups.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no group active, waiting for any pending request
// ST_GREEN0 | group 0 owns the intersection; new grants until stop_new
// ST_GREEN1 | group 1 owns the intersection; new grants until stop_new
// ST_CLEAR  | all red for CLEAR_CYCLES before handing over to ~last_grp
module traffic_arbiter_n #(
   parameter int                  NUM_DIRS     = 4,
   parameter logic [NUM_DIRS-1:0] GROUP_MAP    = 4'b1100,
   parameter int                  MAX_GREEN    = 8,
   parameter int                  CLEAR_CYCLES = 2,
   parameter int                  TW           = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   traffic_arbiter_n_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GREEN0 = 2'b01,
      ST_GREEN1 = 2'b10,
      ST_CLEAR  = 2'b11
   } state_t;

   localparam logic [NUM_DIRS-1:0] MASK_G1   = GROUP_MAP;
   localparam logic [NUM_DIRS-1:0] MASK_G0   = ~GROUP_MAP;
   localparam logic [TW-1:0]       MAX_G     = TW'(MAX_GREEN);
   localparam logic [TW-1:0]       CLR_LAST  = TW'((CLEAR_CYCLES > 0) ? CLEAR_CYCLES - 1 : 0);
   localparam logic [TW-1:0]       TIMER_SAT = '1;
   localparam bit                  HAS_CLEAR = (CLEAR_CYCLES > 0);

   state_t              state, state_nxt;
   logic [NUM_DIRS-1:0] go, go_nxt;
   logic [NUM_DIRS-1:0] pending, pending_nxt;
   logic [NUM_DIRS-1:0] release_v;
   logic [TW-1:0]       timer, timer_nxt;
   logic                stop_new, stop_nxt;
   logic                last_grp, last_nxt;

   logic                cur_grp;
   logic [NUM_DIRS-1:0] mask_cur, mask_oth;
   logic                any_g0, any_g1;
   logic                pend_cur, pend_oth, go_cur;
   logic                do_open, open_grp;

   // A direction releases when its grant is up and the car has gone.
   assign release_v   = go & ~bus.sense;
   assign pending_nxt = (pending & ~release_v) | (bus.sense & ~pending);

   assign any_g0   = |(pending & MASK_G0);
   assign any_g1   = |(pending & MASK_G1);
   assign cur_grp  = (state == ST_GREEN1);
   assign mask_cur = cur_grp ? MASK_G1 : MASK_G0;
   assign mask_oth = cur_grp ? MASK_G0 : MASK_G1;
   assign pend_cur = |(pending & mask_cur);
   assign pend_oth = |(pending & mask_oth);
   assign go_cur   = |(go & mask_cur);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         go       <= '0;
         pending  <= '0;
         timer    <= '0;
         stop_new <= 1'b0;
         last_grp <= 1'b1;
      end else begin
         state    <= state_nxt;
         go       <= go_nxt;
         pending  <= pending_nxt;
         timer    <= timer_nxt;
         stop_new <= stop_nxt;
         last_grp <= last_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      go_nxt    = go & ~release_v;
      timer_nxt = timer;
      stop_nxt  = stop_new;
      last_nxt  = last_grp;
      do_open   = 1'b0;
      open_grp  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (any_g0 || any_g1) begin
               do_open  = 1'b1;
               open_grp = (any_g0 && any_g1) ? ~last_grp : any_g1;
            end
         end

         ST_GREEN0, ST_GREEN1: begin
            if (!go_cur && (stop_new || !pend_cur)) begin
               last_nxt = cur_grp;
               if (pend_oth && HAS_CLEAR) begin
                  state_nxt = ST_CLEAR;
                  timer_nxt = '0;
               end else if (pend_oth) begin
                  do_open  = 1'b1;
                  open_grp = ~cur_grp;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               if (!stop_new) begin
                  go_nxt = go_nxt | (pending & mask_cur & ~go);
               end
               // Fairness cap only runs while the other group is actually waiting.
               if (timer >= MAX_G) begin
                  stop_nxt = 1'b1;
               end
               if (pend_oth && (timer != TIMER_SAT)) begin
                  timer_nxt = timer + 1'b1;
               end
            end
         end

         ST_CLEAR: begin
            if (timer >= CLR_LAST) begin
               do_open  = 1'b1;
               open_grp = ~last_grp;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase

      // Entering a green grants every pending direction of that group on the same edge.
      if (do_open) begin
         state_nxt = open_grp ? ST_GREEN1 : ST_GREEN0;
         go_nxt    = pending & (open_grp ? MASK_G1 : MASK_G0);
         timer_nxt = '0;
         stop_nxt  = 1'b0;
      end
   end

   assign bus.go      = go;
   assign bus.pending = pending;
   assign bus.phase   = state;

endmodule

// File: tb/tb_traffic_arbiter_n.sv
// Bench for traffic_arbiter_n: two builds (with and without clearance) driven by the same sense
// stream, each compared every cycle against a per-direction reference model.
module tb_traffic_arbiter_n;
   localparam int           N    = 4;
   localparam logic [N-1:0] GMAP = 4'b1100;

   logic         clk    = 1'b0;
   logic         rst_n  = 1'b0;
   logic [N-1:0] sense  = '0;
   logic [N-1:0] gmap_v = GMAP;

   int checks = 0;
   int errors = 0;

   traffic_arbiter_n_if #(.NUM_DIRS(N)) if0 ();
   traffic_arbiter_n_if #(.NUM_DIRS(N)) if1 ();

   assign if0.sense = sense;
   assign if1.sense = sense;

   traffic_arbiter_n #(.NUM_DIRS(N), .GROUP_MAP(GMAP), .MAX_GREEN(8), .CLEAR_CYCLES(2), .TW(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0));
   traffic_arbiter_n #(.NUM_DIRS(N), .GROUP_MAP(GMAP), .MAX_GREEN(3), .CLEAR_CYCLES(0), .TW(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1));

   always #5 clk = ~clk;

   logic [N-1:0] d_go[2];
   logic [N-1:0] d_pend[2];
   logic [1:0]   d_ph[2];
   assign d_go[0] = if0.go;   assign d_pend[0] = if0.pending;   assign d_ph[0] = if0.phase;
   assign d_go[1] = if1.go;   assign d_pend[1] = if1.pending;   assign d_ph[1] = if1.phase;

   // Reference model state; phase 0 idle, 1 green0, 2 green1, 3 clear.
   int max_g[2] = '{8, 3};
   int clr_c[2] = '{2, 0};
   bit m_go[2][N];
   bit m_pend[2][N];
   int m_phase[2];
   int m_timer[2];
   int m_last[2];
   bit m_stop[2];

   int wait_cnt[2][N];
   int wait_max[2];
   int seen_grp[2];
   int zero_run[2];

   function automatic int grp_of(input int i);
      return gmap_v[i] ? 1 : 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < N; i++) begin
            m_go[k][i]     = 1'b0;
            m_pend[k][i]   = 1'b0;
            wait_cnt[k][i] = 0;
         end
         m_phase[k]  = 0;
         m_timer[k]  = 0;
         m_stop[k]   = 1'b0;
         m_last[k]   = 1;
         seen_grp[k] = -1;
         zero_run[k] = 0;
      end
   endtask

   task automatic model_step(input int k, input logic [N-1:0] s);
      bit ng[N];
      bit np[N];
      int pend_cnt[2];
      int go_cnt[2];
      int g, o, open_g;
      bit do_open;
      pend_cnt = '{0, 0};
      go_cnt   = '{0, 0};
      for (int i = 0; i < N; i++) begin
         if (m_pend[k][i]) pend_cnt[grp_of(i)]++;
         if (m_go[k][i])   go_cnt[grp_of(i)]++;
         ng[i] = m_go[k][i] && s[i];
         np[i] = (m_go[k][i] && !s[i]) ? 1'b0 : (m_pend[k][i] || s[i]);
      end
      do_open = 1'b0;
      open_g  = 0;
      case (m_phase[k])
         0: begin
            if (pend_cnt[0] + pend_cnt[1] > 0) begin
               do_open = 1'b1;
               if (pend_cnt[0] > 0 && pend_cnt[1] > 0) open_g = 1 - m_last[k];
               else                                    open_g = (pend_cnt[1] > 0) ? 1 : 0;
            end
         end
         1, 2: begin
            g = m_phase[k] - 1;
            o = 1 - g;
            if (go_cnt[g] == 0 && (m_stop[k] || pend_cnt[g] == 0)) begin
               m_last[k] = g;
               if (pend_cnt[o] > 0) begin
                  if (clr_c[k] > 0) begin
                     m_phase[k] = 3;
                     m_timer[k] = 0;
                  end else begin
                     do_open = 1'b1;
                     open_g  = o;
                  end
               end else begin
                  m_phase[k] = 0;
               end
            end else begin
               if (!m_stop[k])
                  for (int i = 0; i < N; i++)
                     if (grp_of(i) == g && m_pend[k][i] && !m_go[k][i]) ng[i] = 1'b1;
               if (m_timer[k] >= max_g[k]) m_stop[k] = 1'b1;
               if (pend_cnt[o] > 0 && m_timer[k] < 255) m_timer[k]++;
            end
         end
         default: begin
            if (m_timer[k] + 1 >= clr_c[k]) begin
               do_open = 1'b1;
               open_g  = 1 - m_last[k];
            end else begin
               m_timer[k]++;
            end
         end
      endcase
      if (do_open) begin
         m_phase[k] = open_g + 1;
         m_timer[k] = 0;
         m_stop[k]  = 1'b0;
         for (int i = 0; i < N; i++) ng[i] = (grp_of(i) == open_g) && m_pend[k][i];
      end
      for (int i = 0; i < N; i++) begin
         m_go[k][i]   = ng[i];
         m_pend[k][i] = np[i];
      end
   endtask

   task automatic check_model(input int k);
      logic [N-1:0] eg, ep;
      logic         a0, a1;
      int           g;
      for (int i = 0; i < N; i++) begin
         eg[i] = m_go[k][i];
         ep[i] = m_pend[k][i];
      end
      checks++;
      if (d_go[k] !== eg) begin
         errors++;
         $display("FAIL model_go dut%0d t=%0t: got %b, expected %b", k, $time, d_go[k], eg);
      end
      checks++;
      if (d_pend[k] !== ep) begin
         errors++;
         $display("FAIL model_pending dut%0d t=%0t: got %b, expected %b", k, $time, d_pend[k], ep);
      end
      checks++;
      if (d_ph[k] !== 2'(m_phase[k])) begin
         errors++;
         $display("FAIL model_phase dut%0d t=%0t: got %b, expected %0d", k, $time, d_ph[k], m_phase[k]);
      end
      a0 = |(d_go[k] & ~gmap_v);
      a1 = |(d_go[k] & gmap_v);
      checks++;
      if (a0 && a1) begin
         errors++;
         $display("FAIL mixed_groups dut%0d t=%0t: go=%b has bits of both groups", k, $time, d_go[k]);
      end
      checks++;
      if ((d_go[k] & ~d_pend[k]) != '0) begin
         errors++;
         $display("FAIL go_without_pending dut%0d t=%0t: go=%b pending=%b", k, $time, d_go[k], d_pend[k]);
      end
      if (a0 || a1) begin
         g = a1 ? 1 : 0;
         if (seen_grp[k] >= 0 && g != seen_grp[k]) begin
            checks++;
            if (zero_run[k] < clr_c[k]) begin
               errors++;
               $display("FAIL clearance_gap dut%0d t=%0t: %0d all-red cycles, expected >= %0d",
                        k, $time, zero_run[k], clr_c[k]);
            end
         end
         seen_grp[k] = g;
         zero_run[k] = 0;
      end else begin
         zero_run[k]++;
      end
      for (int i = 0; i < N; i++) begin
         if (d_pend[k][i] && !d_go[k][i]) wait_cnt[k][i]++;
         else                             wait_cnt[k][i] = 0;
         if (wait_cnt[k][i] > wait_max[k]) wait_max[k] = wait_cnt[k][i];
      end
   endtask

   task automatic cycle(input logic [N-1:0] s);
      sense = s;
      @(posedge clk);
      model_step(0, s);
      model_step(1, s);
      @(negedge clk);
      check_model(0);
      check_model(1);
   endtask

   task automatic pin(input string name, input int k, input logic [N-1:0] eg,
                      input logic [N-1:0] ep, input logic [1:0] eph);
      checks++;
      if (d_go[k] !== eg || d_pend[k] !== ep || d_ph[k] !== eph) begin
         errors++;
         $display("FAIL %s dut%0d: go=%b pending=%b phase=%b, expected go=%b pending=%b phase=%b",
                  name, k, d_go[k], d_pend[k], d_ph[k], eg, ep, eph);
      end
   endtask

   initial begin
      logic [N-1:0] s;
      wait_max = '{0, 0};
      model_reset();
      repeat (2) @(negedge clk);
      pin("reset_state", 0, 4'b0000, 4'b0000, 2'b00);
      pin("reset_state", 1, 4'b0000, 4'b0000, 2'b00);
      rst_n = 1'b1;

      // Single request, grant and release.
      cycle(4'b0001);
      for (int k = 0; k < 2; k++) pin("t1_latch", k, 4'b0000, 4'b0001, 2'b00);
      cycle(4'b0001);
      for (int k = 0; k < 2; k++) pin("t1_grant", k, 4'b0001, 4'b0001, 2'b01);
      cycle(4'b0001);
      cycle(4'b0001);
      cycle(4'b0000);
      for (int k = 0; k < 2; k++) pin("t1_release", k, 4'b0000, 4'b0000, 2'b01);
      cycle(4'b0000);
      for (int k = 0; k < 2; k++) pin("t1_idle", k, 4'b0000, 4'b0000, 2'b00);

      // Two compatible directions together, one releases early.
      cycle(4'b0011);
      cycle(4'b0011);
      for (int k = 0; k < 2; k++) pin("t2_grant_pair", k, 4'b0011, 4'b0011, 2'b01);
      cycle(4'b0001);
      for (int k = 0; k < 2; k++) pin("t2_partial_release", k, 4'b0001, 4'b0001, 2'b01);
      cycle(4'b0000);
      cycle(4'b0000);
      for (int k = 0; k < 2; k++) pin("t2_idle", k, 4'b0000, 4'b0000, 2'b00);

      // Held group 0 with group 1 waiting: stop_new blocks late same-group requests.
      cycle(4'b0001);
      cycle(4'b0001);
      cycle(4'b0101);
      repeat (10) cycle(4'b0001);
      repeat (3) cycle(4'b0011);
      for (int k = 0; k < 2; k++) pin("t3_stop_new_holds", k, 4'b0001, 4'b0111, 2'b01);
      cycle(4'b0010);
      for (int k = 0; k < 2; k++) pin("t3_drop", k, 4'b0000, 4'b0110, 2'b01);
      cycle(4'b0010);
      pin("t3_clear_a", 0, 4'b0000, 4'b0110, 2'b11);
      pin("t3_direct", 1, 4'b0100, 4'b0110, 2'b10);
      cycle(4'b0010);
      pin("t3_clear_b", 0, 4'b0000, 4'b0110, 2'b11);
      cycle(4'b0010);
      pin("t3_grant_other", 0, 4'b0100, 4'b0110, 2'b10);

      // Asynchronous reset while a grant is active.
      #2;
      rst_n = 1'b0;
      sense = '0;
      #1;
      for (int k = 0; k < 2; k++) pin("t5_async_reset", k, 4'b0000, 4'b0000, 2'b00);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Simultaneous cross-group requests from reset: group 0 first.
      cycle(4'b1001);
      cycle(4'b1001);
      for (int k = 0; k < 2; k++) pin("t4_group0_first", k, 4'b0001, 4'b1001, 2'b01);
      cycle(4'b1000);
      for (int k = 0; k < 2; k++) pin("t4_release", k, 4'b0000, 4'b1000, 2'b01);
      cycle(4'b1000);
      pin("t4_clearing", 0, 4'b0000, 4'b1000, 2'b11);
      pin("t4_direct", 1, 4'b1000, 4'b1000, 2'b10);
      cycle(4'b1000);
      cycle(4'b1000);
      pin("t4_other_group", 0, 4'b1000, 4'b1000, 2'b10);

      // Direct handover with no clearance in the second build.
      cycle(4'b1001);
      cycle(4'b0001);
      pin("t6_release", 1, 4'b0000, 4'b0001, 2'b10);
      cycle(4'b0001);
      pin("t6_direct_switch", 1, 4'b0001, 4'b0001, 2'b01);

      // Random traffic; granted cars leave with probability 1/2 each cycle.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (m_go[0][i] || m_go[1][i]) s[i] = ($urandom_range(0, 1) == 0);
            else                          s[i] = ($urandom_range(0, 3) == 0);
         end
         cycle(s);
      end

      for (int k = 0; k < 2; k++) begin
         checks++;
         if (wait_max[k] > 100) begin
            errors++;
            $display("FAIL liveness dut%0d: longest wait %0d cycles, expected <= 100", k, wait_max[k]);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
